// File: rtl/btn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | btn_pkg : shared state encoding and sizing helper for the button |
// | conditioner.                                      rev 1.0        |
// +------------------------------------------------------------------+
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_LONG_HELD    = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_t;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int unsigned max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | bit_sync : multi-flop synchronizer, asynchronous reset to a      |
// | chosen idle level.                                rev 1.0        |
// +------------------------------------------------------------------+
module bit_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | button_conditioner : raw push-button to clean level plus press,  |
// | release, long-press and auto-repeat strobes.      rev 1.0        |
// +------------------------------------------------------------------+
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 12_500_000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam bit                REP_EN    = (REPEAT_CYCLES != 0);
  localparam logic              SYNC_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic pad_sync;
  logic s;

  bit_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (SYNC_IDLE)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button_in),
    .q     (pad_sync)
  );

  assign s = pad_sync ^ ACTIVE_LOW;

  btn_state_t        state_q,     state_d;
  logic [DEB_W-1:0]  deb_cnt_q,   deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q,   rep_cnt_d;
  logic              long_seen_q, long_seen_d;
  logic              level_q,     level_d;
  logic              press_q,     press_d;
  logic              release_q,   release_d;
  logic              long_q,      long_d;
  logic              repeat_q,    repeat_d;
  logic              held_tick;

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    long_seen_d = long_seen_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    held_tick   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d   = ST_PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = ST_PRESSED;
          level_d    = 1'b1;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      ST_PRESSED, ST_LONG_HELD: begin
        if (!s) begin
          state_d   = ST_RELEASE_WAIT;
          deb_cnt_d = '0;
        end else begin
          held_tick = 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        // A bounce back high resumes the hold and counts as a held cycle,
        // so the frozen interval is exactly the time the input read low.
        if (s) begin
          held_tick = 1'b1;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = ST_IDLE;
          level_d     = 1'b0;
          release_d   = 1'b1;
          long_seen_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (held_tick) begin
      if (!long_seen_q) begin
        state_d = ST_PRESSED;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = ST_LONG_HELD;
          long_d      = 1'b1;
          long_seen_d = 1'b1;
          rep_cnt_d   = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end else begin
        state_d = ST_LONG_HELD;
        if (REP_EN) begin
          if (rep_cnt_q == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      long_seen_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      long_seen_q <= long_seen_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign button_level  = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_button_conditioner : directed and random pad stimulus against |
// | a sample-counting reference model.                rev 1.0        |
// +------------------------------------------------------------------+
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  logic clk = 1'b0;
  logic reset;
  logic button_in;
  logic button_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  button_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .REPEAT_CYCLES   (REP),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button_in     (button_in),
    .button_level  (button_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: pad delay line, then counting of consecutive samples.
  bit hist[$];
  int run, n_held, m_rep;
  bit m_level, m_long;
  bit e_press, e_release, e_long, e_repeat;

  // Observed strobe bookkeeping.
  int n_press = 0, n_release = 0, n_long = 0;
  int last_press = -1, last_release = -1, last_long = -1;
  int rep_q[$];

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    run = 0; n_held = 0; m_rep = 0; m_level = 0; m_long = 0;
    e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
  endtask

  task automatic model_step(input bit pad);
    bit s;
    s = hist.pop_front();
    hist.push_back(pad);
    e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
    if (s != m_level) begin
      // A level change is accepted after DEB samples beyond the first one seen.
      run++;
      if (run == DEB + 1) begin
        run = 0;
        if (!m_level) begin
          e_press = 1; m_level = 1; n_held = 0; m_long = 0;
        end else begin
          e_release = 1; m_level = 0; m_long = 0;
        end
      end
    end else begin
      run = 0;
      if (m_level) begin
        if (!m_long) begin
          n_held++;
          if (n_held == LONG) begin
            e_long = 1; m_long = 1; m_rep = 0;
          end
        end else begin
          m_rep++;
          if (m_rep == REP) begin
            e_repeat = 1; m_rep = 0;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("button_level",  button_level,  m_level);
    check("press_pulse",   press_pulse,   e_press);
    check("release_pulse", release_pulse, e_release);
    check("long_pulse",    long_pulse,    e_long);
    check("repeat_pulse",  repeat_pulse,  e_repeat);
  endtask

  task automatic tick(input bit pad);
    button_in = pad;
    @(posedge clk);
    if (reset) model_reset();
    else       model_step(pad);
    #1;
    check_outputs();
    if (press_pulse)   begin n_press++;   last_press   = cyc; end
    if (release_pulse) begin n_release++; last_release = cyc; end
    if (long_pulse)    begin n_long++;    last_long    = cyc; end
    if (repeat_pulse)  rep_q.push_back(cyc);
    cyc++;
  endtask

  task automatic hold_until_press(output int pcyc);
    int start;
    start = n_press;
    pcyc  = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1);
      if (n_press != start) begin
        pcyc = last_press;
        break;
      end
    end
    if (pcyc < 0) check_int("press_timeout", n_press - start, 1);
  endtask

  task automatic release_fully();
    for (int i = 0; i < 8; i++) tick(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c0, p, cnt0, rel0, lng0, lvl, len;
    bit glitch [20];

    // Reset state.
    reset     = 1'b1;
    button_in = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0);

    // Clean press, then long hold with repeats.
    c0 = cyc;
    hold_until_press(p);
    check_int("press_latency", p - c0, SYNC + DEB);
    rep_q.delete();
    while (cyc <= p + 40) tick(1'b1);
    check_int("long_offset", last_long - p, LONG);
    check_int("repeat_count", rep_q.size(), 4);
    for (int i = 0; i < 4 && i < rep_q.size(); i++)
      check_int("repeat_offset", rep_q[i] - p, LONG + REP * (i + 1));

    // Short release bounce while in long hold: repeat phase slips by two.
    rel0 = n_release;
    rep_q.delete();
    tick(1'b0);
    tick(1'b0);
    while (cyc <= p + 52) tick(1'b1);
    check_int("bounce_no_release", n_release - rel0, 0);
    check_int("bounce_repeat_count", rep_q.size(), 2);
    if (rep_q.size() == 2) begin
      check_int("bounce_repeat0", rep_q[0] - p, 47);
      check_int("bounce_repeat1", rep_q[1] - p, 52);
    end
    release_fully();
    check_int("release_after_hold", n_release - rel0, 1);

    // Glitchy press: only the final stable run is accepted.
    glitch = '{1,0,1,1,0,1,1,1,0,0,1,1,1,1,1,1,1,1,1,1};
    cnt0 = n_press;
    foreach (glitch[i]) tick(glitch[i]);
    check_int("glitch_press_count", n_press - cnt0, 1);
    release_fully();

    // Release observed on the very cycle the hold counter expires.
    lng0 = n_long;
    hold_until_press(p);
    for (int i = 0; i < LONG - SYNC - 1; i++) tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    check_int("expiry_no_long", n_long - lng0, 0);
    check_int("expiry_release_offset", last_release - p, LONG + DEB);

    // Reset while in long hold, pad kept pressed.
    lng0 = n_long;
    hold_until_press(p);
    for (int i = 0; i < 30 && n_long == lng0; i++) tick(1'b1);
    check_int("reached_long", n_long - lng0, 1);
    tick(1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    tick(1'b1);
    tick(1'b1);
    reset = 1'b0;
    c0 = cyc;
    hold_until_press(p);
    check_int("press_after_reset", p - c0, SYNC + DEB);
    release_fully();

    // Random pad activity.
    for (int r = 0; r < 60; r++) begin
      lvl = $urandom_range(0, 1);
      len = (r % 5 == 0) ? $urandom_range(20, 45) : $urandom_range(1, 7);
      for (int k = 0; k < len; k++) tick(lvl[0]);
    end
    for (int i = 0; i < 10; i++) tick(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
